// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: strobes COL, senses ROW, debounces and reports a hex key code.
// Optional auto-repeat of key_valid while a key is held: define KEYPAD_REPEAT_EN.
module keypad_scanner #(
    parameter int SETTLE_CYCLES       = 1000,
    parameter int DEBOUNCE_CYCLES     = 1000000,
    parameter int REPEAT_DELAY_CYCLES = 50000000,
    parameter int REPEAT_RATE_CYCLES  = 10000000
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [3:0] COL,
    input  logic [3:0] ROW,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    localparam int CNT_MAX = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES : DEBOUNCE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] SETTLE_LAST   = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEBOUNCE_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [3:0]       r_rowMeta;
    logic [3:0]       r_rowSync;
    logic [1:0]       r_col;
    logic [1:0]       w_nextCol;
    logic [1:0]       r_row;
    logic [1:0]       w_nextRow;
    logic [1:0]       w_lowRow;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_nextCnt;
    logic [3:0]       r_keyCode;
    logic             r_keyValid;
    logic             r_keyDown;
    logic             w_accept;
    logic             w_repeatPulse;
    logic             w_candLow;
    logic             w_anyLow;
    logic [3:0]       w_keyMapped;

    function automatic logic [3:0] keyMap(input logic [1:0] col, input logic [1:0] row);
        logic [3:0] code;
        case ({col, row})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h4;
            4'b00_10: code = 4'h7;
            4'b00_11: code = 4'h0;
            4'b01_00: code = 4'h2;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h8;
            4'b01_11: code = 4'hF;
            4'b10_00: code = 4'h3;
            4'b10_01: code = 4'h6;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hE;
            4'b11_00: code = 4'hA;
            4'b11_01: code = 4'hB;
            4'b11_10: code = 4'hC;
            default:  code = 4'hD;
        endcase
        return code;
    endfunction

    // ROW is asynchronous to clk; the synchronizer idles high like the pulled-up lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rowMeta <= 4'hF;
            r_rowSync <= 4'hF;
        end else begin
            r_rowMeta <= ROW;
            r_rowSync <= r_rowMeta;
        end
    end

    assign w_candLow   = ~r_rowSync[r_row];
    assign w_anyLow    = ~&r_rowSync;
    assign w_keyMapped = keyMap(r_col, r_row);

    always_comb begin
        w_lowRow = 2'd3;
        if (!r_rowSync[2]) w_lowRow = 2'd2;
        if (!r_rowSync[1]) w_lowRow = 2'd1;
        if (!r_rowSync[0]) w_lowRow = 2'd0;
    end

    // One counter serves as settle timer, press debouncer and release debouncer in turn.
    always_comb begin
        w_nextState = r_state;
        w_nextCol   = r_col;
        w_nextRow   = r_row;
        w_nextCnt   = r_cnt;
        w_accept    = 1'b0;
        case (r_state)
            SCAN: begin
                if (r_cnt == SETTLE_LAST) begin
                    w_nextCnt = '0;
                    if (w_anyLow) begin
                        w_nextRow   = w_lowRow;
                        w_nextState = DEBOUNCE;
                    end else begin
                        w_nextCol = r_col + 2'd1;
                    end
                end else begin
                    w_nextCnt = r_cnt + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (!w_candLow) begin
                    w_nextState = SCAN;
                    w_nextCnt   = '0;
                    w_nextCol   = r_col + 2'd1;
                end else if (r_cnt == DEBOUNCE_LAST) begin
                    w_nextState = PRESSED;
                    w_nextCnt   = '0;
                    w_accept    = 1'b1;
                end else begin
                    w_nextCnt = r_cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (w_candLow) begin
                    w_nextCnt = '0;
                end else if (r_cnt == DEBOUNCE_LAST) begin
                    w_nextState = SCAN;
                    w_nextCnt   = '0;
                    w_nextCol   = r_col + 2'd1;
                end else begin
                    w_nextCnt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_nextState = SCAN;
                w_nextCnt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= SCAN;
            r_col      <= 2'd0;
            r_row      <= 2'd0;
            r_cnt      <= '0;
            r_keyCode  <= 4'h0;
            r_keyValid <= 1'b0;
            r_keyDown  <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_col      <= w_nextCol;
            r_row      <= w_nextRow;
            r_cnt      <= w_nextCnt;
            r_keyValid <= w_accept | w_repeatPulse;
            r_keyDown  <= (w_nextState == PRESSED);
            if (w_accept) begin
                r_keyCode <= w_keyMapped;
            end
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ? REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
    localparam int REP_W   = $clog2(REP_MAX);
    localparam logic [REP_W-1:0] DELAY_LAST = REP_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [REP_W-1:0] RATE_LAST  = REP_W'(REPEAT_RATE_CYCLES - 1);

    logic [REP_W-1:0] r_repCnt;
    logic [REP_W-1:0] w_nextRepCnt;
    logic             r_repArmed;
    logic             w_nextRepArmed;

    // The repeat counter only advances on clocks the row reads low, so a bounce pauses it.
    always_comb begin
        w_repeatPulse  = 1'b0;
        w_nextRepCnt   = r_repCnt;
        w_nextRepArmed = r_repArmed;
        if (r_state != PRESSED) begin
            w_nextRepCnt   = '0;
            w_nextRepArmed = 1'b0;
        end else if (w_candLow) begin
            if (!r_repArmed) begin
                if (r_repCnt == DELAY_LAST) begin
                    w_repeatPulse  = 1'b1;
                    w_nextRepCnt   = '0;
                    w_nextRepArmed = 1'b1;
                end else begin
                    w_nextRepCnt = r_repCnt + 1'b1;
                end
            end else if (r_repCnt == RATE_LAST) begin
                w_repeatPulse = 1'b1;
                w_nextRepCnt  = '0;
            end else begin
                w_nextRepCnt = r_repCnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_repCnt   <= '0;
            r_repArmed <= 1'b0;
        end else begin
            r_repCnt   <= w_nextRepCnt;
            r_repArmed <= w_nextRepArmed;
        end
    end
`else
    logic w_unusedRepeat;
    assign w_unusedRepeat = ^{REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES};
    assign w_repeatPulse  = 1'b0;
`endif

    assign COL       = ~(4'b0001 << r_col);
    assign key_code  = r_keyCode;
    assign key_valid = r_keyValid;
    assign key_down  = r_keyDown;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed self-checking bench for keypad_scanner with a behavioural 4x4 keypad model.
// Build with KEYPAD_REPEAT_EN defined to also exercise auto-repeat.
module tb_keypad_scanner;

    localparam int SETTLE = 8;
    localparam int DEB    = 16;
`ifdef KEYPAD_REPEAT_EN
    localparam int EXTRA_HOLD = 20;
`else
    localparam int EXTRA_HOLD = 160;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  COL;
    logic [3:0]  ROW;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_down;
    logic [15:0] heldKeys = '0;

    int checks = 0;
    int failures = 0;

    keypad_scanner #(
        .SETTLE_CYCLES      (SETTLE),
        .DEBOUNCE_CYCLES    (DEB),
        .REPEAT_DELAY_CYCLES(40),
        .REPEAT_RATE_CYCLES (20)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .COL      (COL),
        .ROW      (ROW),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_down (key_down)
    );

    always #5 clk = ~clk;

    // Keypad model: a held key at (c,r) pulls ROW[r] low while its column is driven low.
    always_comb begin
        ROW = 4'hF;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (heldKeys[c*4 + r] && (COL[c] == 1'b0)) ROW[r] = 1'b0;
            end
        end
    end

    function automatic logic [15:0] keyOf(input int c, input int r);
        logic [15:0] one;
        one = 16'd1;
        return one << (c*4 + r);
    endfunction

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [15:0] keys);
        heldKeys = keys;
    endtask

    task automatic holdSteps(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            stepClock();
            if (key_valid === 1'b1) pulses++;
        end
    endtask

    task automatic waitValid(input int limit, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            stepClock();
            if (key_valid === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic waitCol(input logic [3:0] target, input int limit, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            stepClock();
            if (COL === target) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({COL, key_code, key_valid, key_down} !== {4'b1110, 4'h0, 1'b0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL reset_async: got %b expected %b", {COL, key_code, key_valid, key_down}, {4'b1110, 4'h0, 1'b0, 1'b0});
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({COL, key_code, key_valid, key_down} !== {4'b1110, 4'h0, 1'b0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL reset_held: got %b expected %b", {COL, key_code, key_valid, key_down}, {4'b1110, 4'h0, 1'b0, 1'b0});
        end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_idle_scan();
        logic [3:0] expCol;
        for (int k = 1; k <= 64; k++) begin
            stepClock();
            expCol = 4'b1111;
            expCol[(k / SETTLE) % 4] = 1'b0;
            checks++;
            if ({COL, key_valid, key_down, key_code} !== {expCol, 1'b0, 1'b0, 4'h0}) begin
                failures++;
                $display("[TB] FAIL idle_scan cycle %0d: got %b expected %b", k, {COL, key_valid, key_down, key_code}, {expCol, 1'b0, 1'b0, 4'h0});
            end
        end
    endtask

    task automatic test_single_press();
        bit seen;
        int p1, p2, p3;
        applyStimulus(keyOf(2, 1));
        waitValid(200, seen);
        checks++;
        if (seen !== 1'b1) begin
            failures++;
            $display("[TB] FAIL press_accept: got seen=%0b expected seen=1", seen);
        end
        checks++;
        if (key_code !== 4'h6) begin
            failures++;
            $display("[TB] FAIL press_code: got %h expected 6", key_code);
        end
        holdSteps(EXTRA_HOLD, p1);
        checks++;
        if (key_down !== 1'b1) begin
            failures++;
            $display("[TB] FAIL press_down: got %b expected 1", key_down);
        end
        applyStimulus('0);
        holdSteps(DEB + 1, p2);
        checks++;
        if (key_down !== 1'b1) begin
            failures++;
            $display("[TB] FAIL release_before_end: got key_down=%b expected 1", key_down);
        end
        holdSteps(1, p3);
        checks++;
        if ({key_down, COL, key_code} !== {1'b0, 4'b0111, 4'h6}) begin
            failures++;
            $display("[TB] FAIL release_end: got %b expected %b", {key_down, COL, key_code}, {1'b0, 4'b0111, 4'h6});
        end
        checks++;
        if (p1 + p2 + p3 !== 0) begin
            failures++;
            $display("[TB] FAIL press_single_valid: got %0d extra pulses expected 0", p1 + p2 + p3);
        end
    endtask

    task automatic test_short_press();
        bit seen;
        int p1, p2, p3;
        waitCol(4'b1101, 64, seen);
        checks++;
        if (seen !== 1'b1) begin
            failures++;
            $display("[TB] FAIL short_wait_col1: got seen=%0b expected seen=1", seen);
        end
        applyStimulus(keyOf(1, 3));
        holdSteps(10, p1);
        applyStimulus('0);
        holdSteps(2, p2);
        checks++;
        if (COL !== 4'b1101) begin
            failures++;
            $display("[TB] FAIL short_col_held: got %b expected 1101", COL);
        end
        holdSteps(1, p3);
        checks++;
        if ({COL, key_code, key_down} !== {4'b1011, 4'h6, 1'b0}) begin
            failures++;
            $display("[TB] FAIL short_abort: got %b expected %b", {COL, key_code, key_down}, {4'b1011, 4'h6, 1'b0});
        end
        checks++;
        if (p1 + p2 + p3 !== 0) begin
            failures++;
            $display("[TB] FAIL short_no_valid: got %0d pulses expected 0", p1 + p2 + p3);
        end
    endtask

    task automatic test_simultaneous();
        bit seen;
        int p1, p2;
        applyStimulus(keyOf(0, 0) | keyOf(0, 2));
        waitValid(200, seen);
        checks++;
        if ({seen, key_code} !== {1'b1, 4'h1}) begin
            failures++;
            $display("[TB] FAIL same_col_lowest_row: got %b expected %b", {seen, key_code}, {1'b1, 4'h1});
        end
        holdSteps(EXTRA_HOLD, p1);
        applyStimulus('0);
        holdSteps(30, p2);
        checks++;
        if ({p1 + p2 == 0, key_down} !== {1'b1, 1'b0}) begin
            failures++;
            $display("[TB] FAIL same_col_single: got pulses=%0d key_down=%b expected pulses=0 key_down=0", p1 + p2, key_down);
        end
        applyStimulus(keyOf(3, 2));
        waitValid(200, seen);
        checks++;
        if ({seen, key_code} !== {1'b1, 4'hC}) begin
            failures++;
            $display("[TB] FAIL key_c: got %b expected %b", {seen, key_code}, {1'b1, 4'hC});
        end
        holdSteps(EXTRA_HOLD, p1);
        applyStimulus('0);
        holdSteps(30, p2);
        checks++;
        if ({p1 + p2 == 0, key_down} !== {1'b1, 1'b0}) begin
            failures++;
            $display("[TB] FAIL key_c_single: got pulses=%0d key_down=%b expected pulses=0 key_down=0", p1 + p2, key_down);
        end
    endtask

    task automatic test_release_bounce();
        bit seen;
        bit dropped;
        int p1, p2, p3;
        applyStimulus(keyOf(2, 2));
        waitValid(200, seen);
        checks++;
        if ({seen, key_code} !== {1'b1, 4'h9}) begin
            failures++;
            $display("[TB] FAIL bounce_accept: got %b expected %b", {seen, key_code}, {1'b1, 4'h9});
        end
        holdSteps(5, p1);
        dropped = 1'b0;
        applyStimulus('0);
        for (int i = 0; i < 10; i++) begin
            stepClock();
            if (key_down !== 1'b1) dropped = 1'b1;
            if (key_valid === 1'b1) p1++;
        end
        applyStimulus(keyOf(2, 2));
        for (int i = 0; i < 20; i++) begin
            stepClock();
            if (key_down !== 1'b1) dropped = 1'b1;
            if (key_valid === 1'b1) p1++;
        end
        checks++;
        if (dropped !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bounce_down_held: got dropped=%b expected 0", dropped);
        end
        checks++;
        if (p1 !== 0) begin
            failures++;
            $display("[TB] FAIL bounce_no_revalid: got %0d pulses expected 0", p1);
        end
        applyStimulus('0);
        holdSteps(DEB + 1, p2);
        checks++;
        if (key_down !== 1'b1) begin
            failures++;
            $display("[TB] FAIL bounce_release_early: got key_down=%b expected 1", key_down);
        end
        holdSteps(1, p3);
        checks++;
        if ({key_down, key_code, p2 + p3 == 0} !== {1'b0, 4'h9, 1'b1}) begin
            failures++;
            $display("[TB] FAIL bounce_release_end: got %b expected %b", {key_down, key_code, p2 + p3 == 0}, {1'b0, 4'h9, 1'b1});
        end
        holdSteps(12, p3);
    endtask

    task automatic test_reset_mid();
        bit seen1, seen2, seen;
        int p;
        waitCol(4'b1011, 64, seen1);
        applyStimulus(keyOf(3, 0));
        waitCol(4'b0111, 64, seen2);
        holdSteps(10, p);
        checks++;
        if ({seen1, seen2, COL, key_down, key_code} !== {1'b1, 1'b1, 4'b0111, 1'b0, 4'h9}) begin
            failures++;
            $display("[TB] FAIL mid_debounce_setup: got %b expected %b", {seen1, seen2, COL, key_down, key_code}, {1'b1, 1'b1, 4'b0111, 1'b0, 4'h9});
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({COL, key_code, key_valid, key_down} !== {4'b1110, 4'h0, 1'b0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL reset_async_debounce: got %b expected %b", {COL, key_code, key_valid, key_down}, {4'b1110, 4'h0, 1'b0, 1'b0});
        end
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        waitValid(200, seen);
        checks++;
        if ({seen, key_code} !== {1'b1, 4'hA}) begin
            failures++;
            $display("[TB] FAIL reset_recover_accept: got %b expected %b", {seen, key_code}, {1'b1, 4'hA});
        end
        holdSteps(5, p);
        checks++;
        if (key_down !== 1'b1) begin
            failures++;
            $display("[TB] FAIL mid_pressed_setup: got key_down=%b expected 1", key_down);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({COL, key_code, key_valid, key_down} !== {4'b1110, 4'h0, 1'b0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL reset_async_pressed: got %b expected %b", {COL, key_code, key_valid, key_down}, {4'b1110, 4'h0, 1'b0, 1'b0});
        end
        applyStimulus('0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
    endtask

`ifdef KEYPAD_REPEAT_EN
    task automatic test_repeat();
        bit seen;
        int p;
        int pulseAt[$];
        int expAt[4];
        expAt = '{40, 60, 80, 100};
        applyStimulus(keyOf(1, 1));
        waitValid(200, seen);
        checks++;
        if ({seen, key_code} !== {1'b1, 4'h5}) begin
            failures++;
            $display("[TB] FAIL repeat_accept: got %b expected %b", {seen, key_code}, {1'b1, 4'h5});
        end
        for (int k = 1; k <= 110; k++) begin
            stepClock();
            if (key_valid === 1'b1) pulseAt.push_back(k);
            if (key_code !== 4'h5) p = -1;
        end
        checks++;
        if (pulseAt.size() != 4) begin
            failures++;
            $display("[TB] FAIL repeat_count: got %0d pulses expected 4", pulseAt.size());
        end
        for (int i = 0; i < pulseAt.size() && i < 4; i++) begin
            checks++;
            if (pulseAt[i] != expAt[i]) begin
                failures++;
                $display("[TB] FAIL repeat_pulse%0d: got cycle %0d expected %0d", i, pulseAt[i], expAt[i]);
            end
        end
        applyStimulus('0);
        holdSteps(30, p);
        checks++;
        if ({p == 0, key_down, key_code} !== {1'b1, 1'b0, 4'h5}) begin
            failures++;
            $display("[TB] FAIL repeat_release: got pulses=%0d key_down=%b code=%h expected 0 0 5", p, key_down, key_code);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_idle_scan();
        test_single_press();
        test_short_press();
        test_simultaneous();
        test_release_bounce();
        test_reset_mid();
`ifdef KEYPAD_REPEAT_EN
        test_repeat();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got time limit reached expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scanned-input counterpart to the multiplexed 7-segment display driver: it strobes the columns of a 4x4 matrix keypad (Pmod KYPD style) and reads back the rows.
- Debounces the pressed key and reports it as a 4-bit hex code with a one-cycle valid strobe.
- Sits beside the button/display logic in the top level and feeds key codes into the design, for example into the counter that drives the display.

Parameters:
- SETTLE_CYCLES, 1000, clocks each column is driven before rows are sampled (10 us at 100 MHz); must be >= 4.
- DEBOUNCE_CYCLES, 1000000, clocks a press or a release must be continuously stable to be accepted (10 ms at 100 MHz); must be >= 2.
- REPEAT_DELAY_CYCLES, 50000000, auto-repeat initial delay (used only with KEYPAD_REPEAT_EN).
- REPEAT_RATE_CYCLES, 10000000, auto-repeat period (used only with KEYPAD_REPEAT_EN).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- COL  output  4  column drives, active low, exactly one bit low at any time.
- ROW  input  4  row sense lines, pulled up externally, low = key closed; asynchronous to clk.
- key_code  output  4  hex value of the last accepted key.
- key_valid  output  1  one-cycle pulse when key_code is updated.
- key_down  output  1  high while an accepted key is held.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: COL=4'b1110, key_code=0, key_valid=0, key_down=0, state=SCAN, all counters 0. Reset takes effect immediately, mid-operation included.
- Row synchronizer: ROW passes through a 2-flop synchronizer. All row decisions below use the synchronized value (rs).
- Key map (col,row)->code:
  - col0: 1,4,7,0
  - col1: 2,5,8,F
  - col2: 3,6,9,E
  - col3: A,B,C,D
- FSM state SCAN:
  - The current column is held for SETTLE_CYCLES clocks.
  - On the last clock, rs is sampled.
  - If any bit is low, the lowest-index low row becomes the candidate and the FSM goes to DEBOUNCE with the counter cleared. The column is not advanced.
  - Otherwise the column advances 0->1->2->3->0 and COL updates on the next clock.
- FSM state DEBOUNCE:
  - Column held.
  - Each clock the candidate row is still low: counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the row still low, the FSM goes to PRESSED. On that transition:
    - key_code is loaded.
    - key_valid pulses for exactly 1 clock.
    - key_down is set.
  - If the candidate row reads high on any clock, the press is aborted: back to SCAN at the next column, with no output change.
- FSM state PRESSED:
  - Column held.
  - Release counter increments on each clock the candidate row reads high and clears to 0 on any clock it reads low.
  - At DEBOUNCE_CYCLES the FSM sets key_down=0 and returns to SCAN at the next column.
  - Other keys pressed meanwhile are ignored, including other rows in the same column.
- Output hold: key_code holds its value until the next accepted press. key_valid is never high for two consecutive clocks except via repeat, and then never adjacent.
- Simultaneous keys:
  - In the same column, the lowest row wins.
  - In different columns, the first column scanned wins.
- Counter widths: sized with $clog2 of the largest parameter. No wrap is possible, because every counter saturates at its terminal condition.

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- When defined, in PRESSED:
  - A repeat counter starts at entry.
  - After REPEAT_DELAY_CYCLES of continuous hold, key_valid pulses again with key_code unchanged.
  - Further pulses follow every REPEAT_RATE_CYCLES until release begins.
  - Any clock with the row high stops repeats until the release is resolved. If the row goes low again, the repeat counter resumes from its current value.
- When undefined, there is exactly one key_valid per accepted press, and the REPEAT_* parameters are unused.

Test Plan:
Common bench settings: SETTLE_CYCLES=8, DEBOUNCE_CYCLES=16. The keypad model drives ROW[r]=0 while COL[c]=0 for each held key (c,r).
1. Idle after reset, 64 clocks -> COL cycles 1110,1101,1011,0111, each for 8 clocks; key_valid=0, key_down=0, key_code=0 throughout.
2. Hold (2,1) for 200 clocks, then release -> exactly one key_valid, key_code=6, key_down=1; key_down falls 16 clocks after the synchronized release; scanning resumes at col3.
3. Press (1,3) for only 10 clocks -> no key_valid, key_code unchanged, scan resumes at col2.
4. Hold (0,0) and (0,2) together -> key_code=1, single key_valid; then hold (3,2) alone -> key_code=C.
5. Release bounce: while (2,2) is accepted (code 9), pulse ROW high for 10 clocks, then low, then release -> key_down stays 1 through the bounce, no second key_valid, final release accepted after 16 stable clocks.
6. Assert rst_n=0 for 3 clocks mid-DEBOUNCE and mid-PRESSED -> COL=1110, key_down=0, key_code=0, key_valid=0 immediately, without waiting for a clock edge. With KEYPAD_REPEAT_EN, REPEAT_DELAY_CYCLES=40 and REPEAT_RATE_CYCLES=20, hold (1,1) for 120 clocks -> pulses at acceptance, +40, +60, +80, +100.
